response_framer: RTL
====================

Name: response_framer

Overview:
- Successor to the two-byte response stage. Sits between the command/sensor path and the UART transmitter.
- Captures one request (command code plus a DATA_BYTES-wide sensor payload) and maps the command to a response type code.
- Emits the frame as a byte stream over a valid/ready handshake: type byte, payload bytes MSB-first, optional checksum byte.
- Generalised in payload width and code map. Adds back-pressure, an unknown-command error code and a frame-done pulse.

Parameters:
- DATA_BYTES, 1, payload bytes per frame (1..4).
- MAX_CMD, 8, highest valid sensor command code.
- CODE_BASE, 8'h12, type code for command 1; command n maps to CODE_BASE+n-1.
- STATUS_CODE, 8'h11, type code for command 8'h00 (sensor state request).
- ERROR_CODE, 8'hFF, type code for an unknown command.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- request_valid  in  1  request present.
- request_ready  out  1  block can accept a request.
- request_cmd  in  8  command code.
- request_data  in  8*DATA_BYTES  sensor payload.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART accepts a byte this cycle.
- tx_byte  out  8  outgoing byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; tx_valid=0, tx_byte=8'h00, busy=0, frame_done=0, request_ready=1; byte index=0; captured registers cleared.
- request_ready = (state==IDLE). It is combinational from state, and unaffected by request_valid.
- Accept: request_valid && request_ready at a rising edge latches request_cmd and request_data.
  - The type code is computed and registered into tx_byte in the same edge.
  - tx_valid=1 and busy=1 from the next cycle. Latency from accept to first tx_valid is 1 cycle.
- Type code:
  - cmd==0 gives STATUS_CODE.
  - 1<=cmd<=MAX_CMD gives CODE_BASE+cmd-1, in 8-bit arithmetic with modulo-256 wrap.
  - Anything else gives ERROR_CODE.
  - The payload is still sent for an unknown command, unchanged.
- States:
  - IDLE -> TYPE on accept.
  - TYPE -> DATA on tx accept.
  - DATA stays while byte index < DATA_BYTES-1; otherwise -> CHECK if the checksum is enabled, else -> IDLE.
  - CHECK -> IDLE on tx accept.
- Byte transfer: occurs on an edge with tx_valid && tx_ready.
  - Without a transfer, tx_byte and tx_valid are held stable (no retraction, no change).
  - On a transfer, the next byte is loaded in the same edge and tx_valid stays 1. Back-to-back bytes are possible, one per cycle.
- DATA order: byte index 0 = request_data[8*DATA_BYTES-1 -: 8] (MSB first). The index increments per transfer and clears on entry to IDLE.
- Last-byte transfer: tx_valid=0 and busy=0 next cycle, state=IDLE, frame_done=1 for exactly one cycle.
  - request_ready returns to 1 in that same cycle.
  - A new request can therefore be accepted the cycle after the last byte.
- request_valid while busy is ignored and does not overwrite the captured data. The upstream must hold the request.
- Asynchronous reset mid-frame aborts the frame immediately. No partial-frame recovery; the remaining bytes are lost.
- tx_ready while tx_valid=0 has no effect.

Optional Feature:
- RESPONSE_FRAMER_CHECKSUM_EN defined:
  - After the last payload byte, a CHECK byte is sent: XOR of the type byte and all payload bytes.
  - The checksum accumulates as each byte is loaded into tx_byte.
  - Frame length is DATA_BYTES+2.
- Undefined: no CHECK state and no accumulator; frame length is DATA_BYTES+1.

Decomposition:
- Shared package (sensor_protocol_pkg):
  - state enum IDLE/TYPE/DATA/CHECK;
  - STATUS_CODE, ERROR_CODE, CODE_BASE defaults;
  - command code constants 8'h00..8'h08.
- One natural sub-module: response_code_map, a combinational cmd -> type code function block, reusable by the request decoder.

Test Plan:
- DATA_BYTES=1, cmd=8'h03, data=8'hA5, tx_ready held 1 -> bytes 8'h14, 8'hA5 on consecutive cycles; frame_done pulses once; request_ready high the cycle after.
- DATA_BYTES=2, cmd=8'h01, data=16'hBEEF, tx_ready toggling 1 cycle on / 2 off -> 8'h12, 8'hBE, 8'hEF; tx_byte stable while stalled.
- cmd=8'h00 -> type 8'h11. cmd=8'h09 and cmd=8'h80 -> type 8'hFF, payload still sent.
- Second request_valid (cmd=8'h02) asserted mid-frame -> ignored; accepted only after frame_done; first frame bytes are unaltered.
- reset low mid-DATA -> tx_valid=0 and state IDLE asynchronously, before the next edge; next request produces a clean full frame.
- RESPONSE_FRAMER_CHECKSUM_EN, DATA_BYTES=2, cmd=8'h04, data=16'h0F0F -> 8'h15, 8'h0F, 8'h0F, 8'h15.

Source files
------------

// File: rtl/sensor_protocol_pkg.sv
// sensor_protocol_pkg: framer state encoding, default response type codes and sensor command codes.
package sensor_protocol_pkg;
  typedef enum logic [1:0] {IDLE, TYPE, DATA, CHECK} state_t;
  localparam logic [7:0] STATUS_CODE_DEF = 8'h11;
  localparam logic [7:0] ERROR_CODE_DEF  = 8'hFF;
  localparam logic [7:0] CODE_BASE_DEF   = 8'h12;
  localparam int         MAX_CMD_DEF     = 8;
  localparam logic [7:0] CMD_STATE = 8'h00;
  localparam logic [7:0] CMD_S1    = 8'h01;
  localparam logic [7:0] CMD_S2    = 8'h02;
  localparam logic [7:0] CMD_S3    = 8'h03;
  localparam logic [7:0] CMD_S4    = 8'h04;
  localparam logic [7:0] CMD_S5    = 8'h05;
  localparam logic [7:0] CMD_S6    = 8'h06;
  localparam logic [7:0] CMD_S7    = 8'h07;
  localparam logic [7:0] CMD_S8    = 8'h08;
endpackage

// File: rtl/response_framer_if.sv
// response_framer_if: request handshake and tx byte stream of the response framer.
interface response_framer_if #(parameter int DATA_BYTES = 1);
  logic                    request_valid;
  logic                    request_ready;
  logic [7:0]              request_cmd;
  logic [8*DATA_BYTES-1:0] request_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [7:0]              tx_byte;
  logic                    busy;
  logic                    frame_done;
  modport master (
    output request_valid, request_cmd, request_data, tx_ready,
    input  request_ready, tx_valid, tx_byte, busy, frame_done
  );
  modport slave (
    input  request_valid, request_cmd, request_data, tx_ready,
    output request_ready, tx_valid, tx_byte, busy, frame_done
  );
endinterface

// File: rtl/response_code_map.sv
// response_code_map: combinational command code to response type code mapping.
module response_code_map
  import sensor_protocol_pkg::*;
#(
  parameter int         MAX_CMD     = MAX_CMD_DEF,
  parameter logic [7:0] CODE_BASE   = CODE_BASE_DEF,
  parameter logic [7:0] STATUS_CODE = STATUS_CODE_DEF,
  parameter logic [7:0] ERROR_CODE  = ERROR_CODE_DEF
) (
  input  logic [7:0] i_cmd,
  output logic [7:0] o_code
);
  always_comb
    o_code = (i_cmd == CMD_STATE)     ? STATUS_CODE :
             (i_cmd <= 8'(MAX_CMD))   ? 8'(CODE_BASE + i_cmd - 8'd1) :
                                        ERROR_CODE;
endmodule

// File: rtl/response_framer.sv
// response_framer: streams type byte, payload (MSB first) and, with RESPONSE_FRAMER_CHECKSUM_EN,
// an XOR checksum byte over a valid/ready byte interface.
module response_framer
  import sensor_protocol_pkg::*;
#(
  parameter int         DATA_BYTES  = 1,
  parameter int         MAX_CMD     = MAX_CMD_DEF,
  parameter logic [7:0] CODE_BASE   = CODE_BASE_DEF,
  parameter logic [7:0] STATUS_CODE = STATUS_CODE_DEF,
  parameter logic [7:0] ERROR_CODE  = ERROR_CODE_DEF
) (
  input logic          clock,
  input logic          reset,
  response_framer_if.slave bus
);
  localparam logic [2:0] LAST = 3'(DATA_BYTES - 1);
  state_t                  r_state;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [2:0]              r_idx;
  logic [7:0]              r_byte;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;
  logic [7:0]              w_code;
  logic [7:0]              w_next;
  logic [7:0]              w_csum;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_last;
  logic                    w_payload_end;
  response_code_map #(
    .MAX_CMD(MAX_CMD), .CODE_BASE(CODE_BASE), .STATUS_CODE(STATUS_CODE), .ERROR_CODE(ERROR_CODE)
  ) u_map (.i_cmd(bus.request_cmd), .o_code(w_code));
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [7:0] r_csum;
  // Running XOR of every byte loaded into tx_byte so far
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_csum <= '0;
    else if (w_accept) r_csum <= w_code;
    else if (w_xfer && !w_last && !w_payload_end) r_csum <= r_csum ^ w_next;
  assign w_csum = r_csum;
`else
  localparam bit CSUM_EN = 1'b0;
  assign w_csum = 8'h00;
`endif
  assign w_accept          = bus.request_valid && bus.request_ready;
  assign w_xfer            = r_valid && bus.tx_ready;
  assign w_next            = r_data[8*DATA_BYTES-1 -: 8];
  assign w_payload_end     = (r_state == DATA) && (r_idx == LAST);
  assign w_last            = w_xfer && ((r_state == CHECK) || (w_payload_end && !CSUM_EN));
  assign bus.request_ready = (r_state == IDLE);
  assign bus.tx_valid      = r_valid;
  assign bus.tx_byte       = r_byte;
  assign bus.busy          = r_busy;
  assign bus.frame_done    = r_done;
  // Payload is shifted left per byte so the next outgoing byte is always the top one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_data  <= bus.request_data;
        r_byte  <= w_code;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_state <= TYPE;
      end else if (w_last) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_idx   <= '0;
      end else if (w_xfer && w_payload_end) begin
        r_byte  <= w_csum;
        r_state <= CHECK;
      end else if (w_xfer) begin
        r_byte  <= w_next;
        r_data  <= r_data << 8;
        r_idx   <= (r_state == DATA) ? r_idx + 3'd1 : 3'd0;
        r_state <= DATA;
      end
    end
  end
endmodule
